// File: rtl/servo_pwm.sv
// servo_pwm: RC-servo frame generator. One high pulse per FRAME_CYC-cycle
// frame, width = MIN_CYC + ((pos * SPAN_CYC) >> 8). Position and enable are
// sampled only at frame boundaries, so a pulse is never glitched mid-frame.
// Optional feature macro: SERVO_SLEW_EN limits the applied position change
// per frame to SLEW_STEP (saturating, no overshoot).
module servo_pwm #(
  parameter int FRAME_CYC = 1_000_000,
  parameter int MIN_CYC   = 50_000,
  parameter int SPAN_CYC  = 50_000,
  parameter int SLEW_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] position,
  input  logic       en,
  output logic       servo,
  output logic       frame_start,
  output logic [7:0] pos_applied
);

  localparam int CNT_W  = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int SPAN_W = (SPAN_CYC > 0) ? $clog2(SPAN_CYC + 1) : 1;
  localparam int PROD_W = 8 + SPAN_W;
  localparam int WID_W  = $clog2(MIN_CYC + SPAN_CYC + 1);
  localparam int CMP_W  = ((CNT_W > WID_W) ? CNT_W : WID_W) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_CYC - 1);
  localparam logic [7:0]       POS_RESET = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WID_W-1:0]   width_r, width_s;
  logic [7:0]         pos_r, pos_s;
  logic               servo_r, servo_s;
  logic               fs_r, fs_s;
  logic [7:0]         next_pos_s;
  logic               boundary_s;
  logic [CMP_W-1:0]   cnt_inc_s;

  // Pulse width for a position; the product is kept at full width before the shift.
  function automatic logic [WID_W-1:0] width_of(input logic [7:0] pos);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;
    prod   = PROD_W'(pos) * PROD_W'(SPAN_CYC);
    scaled = prod >> 4'd8;
    return WID_W'(MIN_CYC) + WID_W'(scaled);
  endfunction

`ifdef SERVO_SLEW_EN
  localparam int         STEP_LIM = (SLEW_STEP > 255) ? 255 : ((SLEW_STEP < 0) ? 0 : SLEW_STEP);
  localparam logic [8:0] STEP_C   = 9'(STEP_LIM);

  // Move cur toward target by at most STEP_C, landing exactly on target when close.
  function automatic logic [7:0] slew_to(input logic [7:0] target, input logic [7:0] cur);
    logic [8:0] diff;
    logic [8:0] up;
    logic [8:0] dn;
    logic [7:0] res;
    up = {1'b0, cur} + STEP_C;
    dn = {1'b0, cur} - STEP_C;
    if (target >= cur) begin
      diff = {1'b0, target} - {1'b0, cur};
      if (diff <= STEP_C)     res = target;
      else if (up > 9'd255)   res = 8'd255;
      else                    res = up[7:0];
    end else begin
      diff = {1'b0, cur} - {1'b0, target};
      if (diff <= STEP_C)            res = target;
      else if (STEP_C > {1'b0, cur}) res = 8'd0;
      else                           res = dn[7:0];
    end
    return res;
  endfunction

  assign next_pos_s = slew_to(position, pos_r);
`else
  assign next_pos_s = position;
`endif

  // The counter only wraps at CNT_LAST; >= also recovers from any corrupted count.
  assign boundary_s = (state_r == ST_IDLE) || (cnt_r >= CNT_LAST);
  assign cnt_inc_s  = CMP_W'(cnt_r) + CMP_W'(1'b1);

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1'b1);
    width_s = width_r;
    pos_s   = pos_r;
    servo_s = servo_r;
    fs_s    = 1'b0;
    if (boundary_s) begin
      cnt_s = {CNT_W{1'b0}};
      fs_s  = 1'b1;
      if (en) begin
        pos_s   = next_pos_s;
        width_s = width_of(next_pos_s);
        state_s = ST_PULSE;
        servo_s = 1'b1;
      end else begin
        state_s = ST_HOLD;
        servo_s = 1'b0;
      end
    end else begin
      case (state_r)
        ST_PULSE: begin
          if (cnt_inc_s == CMP_W'(width_r)) begin
            servo_s = 1'b0;
            state_s = ST_HOLD;
          end else begin
            servo_s = 1'b1;
          end
        end
        ST_HOLD: begin
          servo_s = 1'b0;
        end
        default: begin
          state_s = ST_IDLE;
          servo_s = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous reset to a centred position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      width_r <= width_of(POS_RESET);
      pos_r   <= POS_RESET;
      servo_r <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      width_r <= width_s;
      pos_r   <= pos_s;
      servo_r <= servo_s;
      fs_r    <= fs_s;
    end
  end

  assign servo       = servo_r;
  assign frame_start = fs_r;
  assign pos_applied = pos_r;

endmodule

// File: tb/tb_servo_pwm.sv
// Testbench for servo_pwm with FRAME_CYC=1000, MIN_CYC=50, SPAN_CYC=256
// (width = 50 + pos). Directed table of frames, a mid-pulse reset sequence,
// then randomized frames checked against a frame-level reference model.
module tb_servo_pwm;

  localparam int FRAME = 1000;
  localparam int MINC  = 50;
  localparam int SPAN  = 256;
`ifdef SERVO_SLEW_EN
  localparam int STEP  = 4;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] position;
  logic       en;
  logic       servo;
  logic       frame_start;
  logic [7:0] pos_applied;

  int checks;
  int failures;
  int m_pos;

  typedef struct {
    logic [7:0] pos;
    logic       en;
    int         chg_at;
    logic [7:0] chg_pos;
    int         exp_pos;
    int         exp_high;
  } vec_t;

  vec_t tbl[$];

  servo_pwm #(
    .FRAME_CYC(FRAME),
    .MIN_CYC  (MINC),
    .SPAN_CYC (SPAN),
    .SLEW_STEP(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .position   (position),
    .en         (en),
    .servo      (servo),
    .frame_start(frame_start),
    .pos_applied(pos_applied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endfunction

  // Reference: applied position after one enabled boundary.
  function automatic int model_next(input int cur, input int target);
`ifdef SERVO_SLEW_EN
    if (target > cur + STEP) return cur + STEP;
    if (target < cur - STEP) return cur - STEP;
    return target;
`else
    return (cur >= 0) ? target : target;
`endif
  endfunction

  function automatic int model_width(input int p);
    return MINC + (p * SPAN) / 256;
  endfunction

  function automatic void add_vec(input int p, input int e, input int chg_at, input int chg_pos,
                                  input int exp_pos, input int exp_high);
    vec_t v;
    v.pos      = 8'(p);
    v.en       = (e != 0);
    v.chg_at   = chg_at;
    v.chg_pos  = 8'(chg_pos);
    v.exp_pos  = exp_pos;
    v.exp_high = exp_high;
    tbl.push_back(v);
  endfunction

  // Called at a negedge just before a boundary edge; observes one full frame.
  task automatic run_frame(input logic [7:0] p, input logic e, input int chg_at,
                           input logic [7:0] chg_pos, input int exp_pos, input int exp_high,
                           input string tag);
    int hi, fs_bad, sh_bad, pos0, posn;
    hi = 0; fs_bad = 0; sh_bad = 0; pos0 = -1; posn = -1;
    position = p;
    en       = e;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (servo === 1'b1) hi++;
      if (frame_start !== (k == 0)) fs_bad++;
      if (servo !== (k < exp_high)) sh_bad++;
      if (k == 0) pos0 = int'(pos_applied);
      if (k == FRAME - 1) posn = int'(pos_applied);
      if (k == chg_at) begin
        position = chg_pos;
        en       = ~en;
      end
    end
    check({tag, ".frame_start_bad_cycles"}, fs_bad, 0);
    check({tag, ".servo_high_cycles"}, hi, exp_high);
    check({tag, ".servo_shape_bad_cycles"}, sh_bad, 0);
    check({tag, ".pos_applied_start"}, pos0, exp_pos);
    check({tag, ".pos_applied_end"}, posn, exp_pos);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.servo", int'(servo), 0);
    check("reset.frame_start", int'(frame_start), 0);
    check("reset.pos_applied", int'(pos_applied), 128);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    position = 8'd0;
    en       = 1'b0;

`ifdef SERVO_SLEW_EN
    add_vec(140, 1, -1, 0, 132, 182);
    add_vec(140, 1, -1, 0, 136, 186);
    add_vec(140, 1, -1, 0, 140, 190);
    add_vec(140, 1, -1, 0, 140, 190);
    add_vec(138, 1, -1, 0, 138, 188);
    add_vec(0,   0, -1, 0, 138, 0);
    add_vec(0,   1, -1, 0, 134, 184);
    add_vec(255, 1, 20, 0, 138, 188);
    add_vec(0,   1, -1, 0, 134, 184);
`else
    add_vec(0,   1, -1, 0,   0,   50);
    add_vec(255, 1, -1, 0,   255, 305);
    add_vec(128, 1, -1, 0,   128, 178);
    add_vec(10,  1, 20, 200, 10,  60);
    add_vec(200, 1, -1, 0,   200, 250);
    add_vec(77,  0, -1, 0,   200, 0);
    add_vec(33,  1, -1, 0,   33,  83);
    add_vec(2,   1, -1, 0,   2,   52);
    add_vec(0,   1, -1, 0,   0,   50);
    add_vec(255, 0, -1, 0,   0,   0);
`endif

    do_reset();
    foreach (tbl[i]) begin
      run_frame(tbl[i].pos, tbl[i].en, tbl[i].chg_at, tbl[i].chg_pos,
                tbl[i].exp_pos, tbl[i].exp_high, $sformatf("vec%0d", i));
    end

    // Reset asserted at cnt=30 of an enabled pulse.
    m_pos    = tbl[tbl.size() - 1].exp_pos;
    m_pos    = model_next(m_pos, 100);
    position = 8'd100;
    en       = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("midrst.frame_start_k0", int'(frame_start), 1);
        check("midrst.pos_applied_k0", int'(pos_applied), m_pos);
      end
      if (k == 29) check("midrst.servo_k29", int'(servo), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst.servo_after", int'(servo), 0);
    check("midrst.frame_start_after", int'(frame_start), 0);
    check("midrst.pos_applied_after", int'(pos_applied), 128);
    rst   = 1'b0;
    m_pos = 128;

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      int p, e, chg_at, chg_pos, exp_high;
      p       = int'($urandom_range(0, 255));
      e       = ($urandom_range(0, 4) != 0) ? 1 : 0;
      chg_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FRAME - 2)) : -1;
      chg_pos = int'($urandom_range(0, 255));
      if (f == 3) p = 255;
      if (f == 4) p = 0;
      if (e != 0) m_pos = model_next(m_pos, p);
      exp_high = (e != 0) ? model_width(m_pos) : 0;
      run_frame(8'(p), (e != 0), chg_at, 8'(chg_pos), m_pos, exp_high,
                $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
